// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: shared states, mode encodings and default widths
package counter_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} state_t;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRESCALE_W = 4;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: clock-enable divider firing once every divisor+1 run cycles
module tick_prescaler import counter_sequencer_pkg::*; #(
  parameter int W = DEF_PRESCALE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         run,
  input  logic [W-1:0] divisor,
  output logic         enable
);
  logic [W-1:0] pre;
  always_comb enable = run && pre == divisor;
  always_ff @(posedge clk)
    if (reset || clear || !run) pre <= '0;
    else pre <= enable ? '0 : pre + 1'b1;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: programmable interval timer with one-shot and periodic modes
module counter_sequencer import counter_sequencer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_mode,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tick,
  output logic                  done
);
  state_t                  state;
  logic [WIDTH-1:0]        period;
  logic [PRESCALE_W-1:0]   prescale;
  logic                    mode;
  logic                    en;
  logic                    cap;
  always_comb begin
    busy = state == RUN;
    cfg_ready = state != RUN;
    cap = cfg_valid && cfg_ready;
  end
  tick_prescaler #(.W(PRESCALE_W)) u_pre (
    .clk     (clk),
    .reset   (reset),
    .clear   (stop),
    .run     (busy),
    .divisor (prescale),
    .enable  (en)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      period <= '0;
      prescale <= '0;
      mode <= MODE_ONESHOT;
      tick <= 1'b0;
      done <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (cap) begin
        period <= cfg_period;
        prescale <= cfg_prescale;
        mode <= cfg_mode;
      end
      if (state == RUN) begin
        if (stop) begin
          state <= LOADED;
          count <= '0;
        end else if (en) begin
          if (count != period) count <= count + 1'b1;
          else begin
            tick <= 1'b1;
            if (mode == MODE_PERIODIC) count <= '0;
            else begin
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
      end else if (start && state != IDLE) begin
        state <= RUN;
        count <= '0;
      end else if (cap) begin
        state <= LOADED;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed stimulus against a cycle-count model of the timer
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;
  logic       clk = 1'b0;
  logic       reset, cfg_valid, cfg_ready, cfg_mode, start, stop, busy, tick, done;
  logic [3:0] cfg_period, cfg_prescale, count;
  int         n_vec = 0;
  int         n_err = 0;
  bit         armed = 0;
  int         ph = 0;
  int         mp = 0;
  int         mps = 0;
  int         mn = 0;
  bit         mmode = 0;
  bit         mtick = 0;
  bit         mdone = 0;
  int         nt;
  bit         found;
  always #5 clk = ~clk;
  counter_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_mode     (cfg_mode),
    .start        (start),
    .stop         (stop),
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic tk();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int p, input int ps, input logic m);
    cfg_valid = 1'b1;
    cfg_period = 4'(p);
    cfg_prescale = 4'(ps);
    cfg_mode = m;
    tk();
    cfg_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    bit cap, en;
    if (armed) begin
      chk("m_count", 32'(count), 32'(ph == 2 ? (mn / (mps + 1)) % (mp + 1) : ph == 3 ? mp : 0));
      chk("m_busy", 32'(busy), 32'(ph == 2));
      chk("m_ready", 32'(cfg_ready), 32'(ph != 2));
      chk("m_tick", 32'(tick), 32'(mtick));
      chk("m_done", 32'(done), 32'(mdone));
    end
    if (reset) begin
      ph = 0; mp = 0; mps = 0; mmode = 0; mn = 0; mtick = 0; mdone = 0; armed = 1;
    end else begin
      cap = cfg_valid && ph != 2;
      mtick = 0;
      mdone = 0;
      if (ph == 2) begin
        if (stop) ph = 1;
        else begin
          en = (mn % (mps + 1)) == mps;
          mn++;
          if (en && (mn / (mps + 1)) % (mp + 1) == 0) begin
            mtick = 1;
            if (!mmode) begin
              mdone = 1;
              ph = 3;
            end
          end
        end
      end else begin
        if (cap) begin
          mp = int'(cfg_period);
          mps = int'(cfg_prescale);
          mmode = cfg_mode;
        end
        if (start && ph != 0) begin
          ph = 2;
          mn = 0;
        end else if (cap) ph = 1;
      end
    end
  end
  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_prescale = '0; cfg_mode = 1'b0;
    start = 1'b0; stop = 1'b0;
    tk(); tk();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_tick", 32'(tick), 0);
    start = 1'b1; tk(); tk();
    chk("idle_start", 32'(busy), 0);
    start = 1'b0;
    cfg(5, 0, MODE_PERIODIC);
    start = 1'b1; tk(); start = 1'b0;
    tk(); tk(); tk();
    chk("mid_count3", 32'(count), 3);
    reset = 1'b1; tk(); reset = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(cfg_ready), 1);
    chk("mid_rst_tick", 32'(tick), 0);
    start = 1'b1; tk(); tk();
    chk("post_rst_start", 32'(busy), 0);
    start = 1'b0;
    cfg(3, 0, MODE_PERIODIC);
    start = 1'b1; tk(); start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk("per3_count", 32'(count), 32'((c - 1) % 4));
      chk("per3_tick", 32'(tick), 32'(c == 5 || c == 9 || c == 13));
      tk();
    end
    stop = 1'b1; tk(); stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_count", 32'(count), 0);
    cfg(2, 2, MODE_ONESHOT);
    start = 1'b1; tk(); start = 1'b0;
    repeat (9) tk();
    chk("os_tick", 32'(tick), 1);
    chk("os_done", 32'(done), 1);
    chk("os_count", 32'(count), 2);
    chk("os_busy", 32'(busy), 0);
    nt = 0;
    repeat (20) begin tk(); nt += int'(tick) + int'(done); end
    chk("os_quiet", 32'(nt), 0);
    chk("os_hold", 32'(count), 2);
    cfg(5, 0, MODE_PERIODIC);
    start = 1'b1; tk(); start = 1'b0;
    cfg_valid = 1'b1; cfg_period = 4'd7; cfg_prescale = '0; cfg_mode = MODE_PERIODIC;
    tk();
    chk("run_ready", 32'(cfg_ready), 0);
    chk("run_busy", 32'(busy), 1);
    tk();
    stop = 1'b1; tk(); stop = 1'b0;
    chk("hs_busy", 32'(busy), 0);
    chk("hs_count", 32'(count), 0);
    chk("hs_ready", 32'(cfg_ready), 1);
    tk();
    cfg_valid = 1'b0;
    start = 1'b1; tk(); start = 1'b0;
    nt = 0;
    repeat (16) begin tk(); nt += int'(tick); end
    chk("p7_ticks", 32'(nt), 2);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) if (count == 4'd7) found = 1; else tk();
    chk("find_p7", 32'(found), 1);
    stop = 1'b1; tk(); stop = 1'b0;
    chk("stop_en_tick", 32'(tick), 0);
    chk("stop_en_count", 32'(count), 0);
    chk("stop_en_busy", 32'(busy), 0);
    start = 1'b1; tk();
    stop = 1'b1; tk(); start = 1'b0; stop = 1'b0;
    chk("start_stop", 32'(busy), 0);
    cfg_valid = 1'b1; cfg_period = 4'd1; cfg_prescale = '0; cfg_mode = MODE_PERIODIC;
    start = 1'b1; tk(); cfg_valid = 1'b0; start = 1'b0;
    chk("capstart_busy", 32'(busy), 1);
    tk();
    chk("capstart_c1", 32'(count), 1);
    tk();
    chk("capstart_wrap", 32'(count), 0);
    chk("capstart_tick", 32'(tick), 1);
    stop = 1'b1; tk(); stop = 1'b0;
    cfg(0, 1, MODE_PERIODIC);
    start = 1'b1; tk(); start = 1'b0;
    nt = 0;
    repeat (10) begin
      tk();
      nt += int'(tick);
      chk("p0_count", 32'(count), 0);
    end
    chk("p0_ticks", 32'(nt), 5);
    stop = 1'b1; tk(); stop = 1'b0;
    cfg(0, 0, MODE_ONESHOT);
    start = 1'b1; tk(); start = 1'b0;
    tk();
    chk("p0os_done", 32'(done), 1);
    chk("p0os_tick", 32'(tick), 1);
    chk("p0os_busy", 32'(busy), 0);
    tk();
    chk("p0os_done_clr", 32'(done), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Programmable interval-timer controller that sequences a WIDTH-bit up-counter.
- Owns the count register and a clock-enable prescaler.
- Accepts period, prescale and mode configuration through a valid/ready handshake.
- Starts and stops counting on command, and flags terminal count (tick) and one-shot completion (done).
- Sits between a control/register interface and the counter datapath that consumes count and tick.

Parameters:
WIDTH, 4, width of count and cfg_period
PRESCALE_W, 4, width of cfg_prescale; enable rate = 1 per (cfg_prescale+1) RUN cycles

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
cfg_valid  input  1  configuration write request
cfg_ready  output  1  high when a configuration write is accepted (state IDLE, LOADED or DONE)
cfg_period  input  WIDTH  terminal count value P; counter runs 0..P
cfg_prescale  input  PRESCALE_W  prescale divisor minus one
cfg_mode  input  1  0 = one-shot, 1 = periodic
start  input  1  start command (level sampled each cycle)
stop  input  1  stop command
count  output  WIDTH  current count, registered
busy  output  1  high in state RUN
tick  output  1  one-cycle pulse, registered, coincident with count reaching wrap/terminal update
done  output  1  one-cycle pulse on one-shot completion, coincident with entry to DONE

Behaviour:
- Reset (synchronous, active-high, clk and reset as named above):
  - state=IDLE; count=0; prescaler=0; tick=0; done=0; busy=0.
  - Stored period, prescale and mode registers cleared to 0.
  - Reset wins over every other input, including mid-RUN.
- Handshake: a config is captured when cfg_valid && cfg_ready. cfg_ready=1 in IDLE, LOADED and DONE, and 0 in RUN. The capture moves state to LOADED and clears count to 0.
- States:
  - IDLE: start is ignored (no config). A capture moves to LOADED.
  - LOADED: start moves to RUN next cycle, with count=0 and prescaler=0. If a capture and start occur in the same cycle, both take effect and RUN uses the new config.
  - RUN: busy=1. Enable fires in a cycle where prescaler==stored_prescale; the prescaler then goes to 0, otherwise it increments. On enable:
    - If count!=P, count increments.
    - If count==P and mode is periodic, count goes to 0 and tick=1 next cycle.
    - If count==P and mode is one-shot, count holds P, tick=1 and done=1 next cycle, and state goes to DONE.
  - RUN + stop: goes to LOADED next cycle with count=0 and prescaler=0. No tick is issued even if an enable coincides. stop beats start and enable. stop outside RUN is ignored.
  - DONE: count holds P, busy=0.
    - start moves to RUN with count=0.
    - A capture moves to LOADED.
    - A capture together with start moves to RUN with the new config.
- P=0: periodic mode ticks on every enable with count constantly 0. One-shot mode completes on the first enable.
- Wrap: count never exceeds P. Arithmetic is unsigned, WIDTH bits, with no overflow because count<=P<=2^WIDTH-1.
- Period between ticks (periodic): (P+1)*(prescale+1) cycles.
- tick and done are high for exactly one cycle and never high in IDLE or LOADED.
- cfg_valid in RUN is not accepted and has no effect. The requester holds it until cfg_ready.

Decomposition:
- Package counter_sequencer_pkg:
  - state enum {IDLE, LOADED, RUN, DONE}
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
  - default WIDTH/PRESCALE_W constants
- Sub-module tick_prescaler:
  - Inputs: clk, reset, clear, run, divisor.
  - Output: enable pulse.
- The FSM, count register and pulse generation stay in counter_sequencer.

Test Plan:
- Reset mid-RUN: config P=5, prescale=0, periodic; start; at count=3 assert reset for 1 cycle -> next cycle count=0, busy=0, tick=0, cfg_ready=1, start is ignored until a new config is written.
- Periodic, P=3, prescale=0: capture, start at cycle 0 -> count sequence 0,1,2,3,0,1... from cycle 1. tick=1 at cycles 5, 9, 13.
- One-shot, P=2, prescale=2: capture, start -> count advances every 3 cycles (0,1,2). tick=1 and done=1 on a single cycle, state DONE, count holds 2, busy=0, and no further pulses for 20 cycles.
- Handshake: cfg_valid with P=7 during RUN -> cfg_ready=0 and no change. Then stop -> next cycle LOADED, count=0, cfg_ready=1, capture of P=7 succeeds. Then start -> ticks every 8 cycles.
- Simultaneous events:
  - stop with an enable at count==P in periodic mode -> no tick, count=0, LOADED.
  - start+stop in the same cycle in RUN -> LOADED.
  - capture+start in LOADED -> RUN with the new P.
- P=0 periodic, prescale=1 -> count stays 0 and tick pulses every 2 cycles. P=0 one-shot -> done on the first enable.
